fp16_vec_loader: RTL

//  Writer side of the softmax_n vector interface. Accepts a stream of IEEE-754 half-precision words
//  on a valid/ready handshake and assembles them into an N-entry vector. Issues a one-cycle start to

---
 rtl/fp16_pkg.sv | 18 +
 rtl/fp16_sanitize.sv | 30 +++
 rtl/fp16_vec_loader.sv | 116 +++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 field positions, special encodings and the vector loader state encoding.
package fp16_pkg;

    localparam int FP16_EXP_MSB = 14;
    localparam int FP16_EXP_LSB = 10;

    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [15:0] FP16_QNAN     = 16'h7E00;
    localparam logic [4:0]  FP16_EXP_MAX  = 5'h1F;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

endpackage

// File: rtl/fp16_sanitize.sv
// Combinational fp16 clean-up: -0 to +0, optional subnormal flush, canonical quiet NaN.
module fp16_sanitize
    import fp16_pkg::*;
#(
    parameter int W      = 16,
    parameter int FTZ_EN = 1
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [FP16_EXP_MSB-FP16_EXP_LSB:0] exp_f;
    logic [FP16_EXP_LSB-1:0]            mant_f;

    assign exp_f  = din[FP16_EXP_MSB:FP16_EXP_LSB];
    assign mant_f = din[FP16_EXP_LSB-1:0];

    always_comb begin
        dout = din;
        if (exp_f == FP16_EXP_MAX && mant_f != '0) begin
            dout = FP16_QNAN;
        end else if (exp_f == '0 && mant_f == '0) begin
            // both zeros collapse to +0 so downstream compares see one encoding
            dout = FP16_POS_ZERO;
        end else if (exp_f == '0 && FTZ_EN != 0) begin
            dout = FP16_POS_ZERO;
        end
    end

endmodule

// File: rtl/fp16_vec_loader.sv
// Assembles a stream of fp16 words into an N-entry vector, pulses start, holds until done.
// Handshake: a word transfers on a rising clk edge where in_valid and in_ready are both high.
module fp16_vec_loader
    import fp16_pkg::*;
#(
    parameter int N      = 10,
    parameter int W      = 16,
    parameter int FTZ_EN = 1,
    localparam int CW    = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic            in_last,
    input  logic            done,
    output logic [N*W-1:0]  vec_flat,
    output logic            start,
    output logic            busy,
    output logic [CW-1:0]   vec_count,
    output logic            err_short,
    output logic            err_long,
    output logic [1:0]      state_dbg
);

    state_t         state_q, state_d;
    logic           ready_en;
    logic [W-1:0]   vec_q [N];
    logic [W-1:0]   wd    [N];
    logic [N-1:0]   we;
    logic [W-1:0]   san_data;
    logic [CW-1:0]  cnt_inc;
    logic           at_end;
    logic           accept;
    logic           fill_acc;

    fp16_sanitize #(.W(W), .FTZ_EN(FTZ_EN)) u_sanitize (
        .din  (in_data),
        .dout (san_data)
    );

    assign in_ready  = ready_en & ((state_q == ST_FILL) | (state_q == ST_DRAIN));
    assign start     = (state_q == ST_ISSUE);
    assign busy      = (state_q == ST_ISSUE) | (state_q == ST_WAIT);
    assign state_dbg = state_q;
    assign accept    = in_valid & in_ready;
    assign fill_acc  = accept & (state_q == ST_FILL);
    assign cnt_inc   = vec_count + 1'b1;
    assign at_end    = (cnt_inc == CW'(N));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    if (in_last)     state_d = ST_ISSUE;
                    else if (at_end) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (accept && in_last) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (done) state_d = ST_FILL;
            default:  state_d = ST_FILL;
        endcase
    end

    // a short vector writes the current word and zeroes every entry above it in one edge
    always_comb begin
        for (int k = 0; k < N; k++) begin
            we[k] = 1'b0;
            wd[k] = san_data;
            if (fill_acc) begin
                if (CW'(k) == vec_count) begin
                    we[k] = 1'b1;
                end else if (in_last && CW'(k) > vec_count) begin
                    we[k] = 1'b1;
                    wd[k] = FP16_POS_ZERO;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en  <= 1'b0;
            vec_count <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            for (int k = 0; k < N; k++) vec_q[k] <= '0;
        end else begin
            ready_en <= 1'b1;
            for (int k = 0; k < N; k++) begin
                if (we[k]) vec_q[k] <= wd[k];
            end
            if (fill_acc) vec_count <= cnt_inc;
            if (fill_acc && in_last && !at_end) err_short <= 1'b1;
            if (fill_acc && !in_last && at_end) err_long <= 1'b1;
            if (state_q == ST_WAIT && done) vec_count <= '0;
        end
    end

    always_comb begin
        vec_flat = '0;
        for (int k = 0; k < N; k++) vec_flat[k*W +: W] = vec_q[k];
    end

endmodule
